// File: rtl/vote_tally_engine_if.sv
// Panel, readout and result signals of vote_tally_engine.
// ballot_arm_i is present only when VOTE_ARM_EN is defined.
interface vote_tally_engine_if #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_CAND)
);
  logic                mode_i;
  logic [NUM_CAND-1:0] button_i;
`ifdef VOTE_ARM_EN
  logic                ballot_arm_i;
`endif
  logic [SEL_W-1:0]    rd_sel_i;
  logic [CNT_W-1:0]    rd_data_o;
  logic [CNT_W-1:0]    led_o;
  logic                vote_ack_o;
  logic                busy_o;
  logic [CNT_W-1:0]    total_votes_o;
  logic [SEL_W-1:0]    winner_o;
  logic                tie_o;

  modport master (
    output mode_i, button_i, rd_sel_i,
`ifdef VOTE_ARM_EN
    output ballot_arm_i,
`endif
    input  rd_data_o, led_o, vote_ack_o, busy_o, total_votes_o, winner_o, tie_o
  );

  modport slave (
    input  mode_i, button_i, rd_sel_i,
`ifdef VOTE_ARM_EN
    input  ballot_arm_i,
`endif
    output rd_data_o, led_o, vote_ack_o, busy_o, total_votes_o, winner_o, tie_o
  );
endinterface

// File: rtl/vote_tally_engine.sv
// Multi-candidate ballot engine: per-button debounce, one vote per ballot, saturating tallies,
// registered winner/tie. Define VOTE_ARM_EN to require an officer arm before each vote.
module vote_tally_engine #(
  parameter int unsigned NUM_CAND     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEBOUNCE_CYC = 10,
  parameter int unsigned ACK_CYC      = 10,
  parameter int unsigned SEL_W        = $clog2(NUM_CAND)
) (
  input logic                clk,
  input logic                reset_n,
  vote_tally_engine_if.slave bus
);
  localparam int unsigned      DebW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned      AckW    = $clog2(ACK_CYC + 1);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE_CYC);
  localparam logic [AckW-1:0]  AckLast = AckW'(ACK_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StArmed, StAck} state_e;

  state_e                         state_q;
  logic [AckW-1:0]                ack_cnt_q;
  logic [NUM_CAND-1:0][DebW-1:0]  deb_q, deb_d;
  logic [NUM_CAND-1:0]            press_q, press_d;
  logic [NUM_CAND-1:0][CNT_W-1:0] tally_q;
  logic [CNT_W-1:0]               total_q, led_hold_q, best;
  logic                           vote_ack_q, mode_q, tie_q, tie_d, seen;
  logic [SEL_W-1:0]               winner_q, winner_d, press_idx;
  logic                           arm_req;

`ifdef VOTE_ARM_EN
  assign arm_req = bus.ballot_arm_i && !bus.mode_i;
`else
  assign arm_req = !bus.mode_i;
`endif

  // press_d fires on the edge the counter steps onto DebMax, so one pulse per held press.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (!bus.button_i[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] != DebMax) begin
        deb_d[i] = deb_q[i] + DebW'(1);
      end
      press_d[i] = bus.button_i[i] && (deb_q[i] == DebMax - DebW'(1));
    end
  end

  always_comb begin
    press_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (press_q[i]) press_idx = SEL_W'(i);
    end
  end

  always_comb begin
    best     = '0;
    winner_d = '0;
    tie_d    = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] > best) begin
        best     = tally_q[i];
        winner_d = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if ((best != '0) && (tally_q[i] == best)) begin
        tie_d = tie_d | seen;
        seen  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ack_cnt_q  <= '0;
      deb_q      <= '0;
      press_q    <= '0;
      tally_q    <= '0;
      total_q    <= '0;
      led_hold_q <= '0;
      vote_ack_q <= 1'b0;
      mode_q     <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      press_q    <= press_d;
      mode_q     <= bus.mode_i;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
      vote_ack_q <= 1'b0;

      if (bus.mode_i && !mode_q) begin
        led_hold_q <= '0;
      end else if (bus.mode_i && (|press_q)) begin
        led_hold_q <= tally_q[press_idx];
      end

      case (state_q)
        StIdle: begin
          if (arm_req) state_q <= StArmed;
        end
        StArmed: begin
          if (bus.mode_i) begin
            state_q <= StIdle;
          end else if (|press_q) begin
            state_q    <= StAck;
            ack_cnt_q  <= '0;
            vote_ack_q <= 1'b1;
            if (tally_q[press_idx] != CntMax) begin
              tally_q[press_idx] <= tally_q[press_idx] + CNT_W'(1);
            end
            if (total_q != CntMax) total_q <= total_q + CNT_W'(1);
          end
        end
        StAck: begin
          if (ack_cnt_q == AckLast) begin
            state_q <= StIdle;
          end else begin
            ack_cnt_q <= ack_cnt_q + AckW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_o        = (state_q == StAck);
  assign bus.vote_ack_o    = vote_ack_q;
  assign bus.total_votes_o = total_q;
  assign bus.winner_o      = winner_q;
  assign bus.tie_o         = tie_q;
  assign bus.led_o         = bus.mode_i ? led_hold_q : (bus.busy_o ? CntMax : '0);
  assign bus.rd_data_o     = (32'(bus.rd_sel_i) < NUM_CAND) ? tally_q[bus.rd_sel_i] : '0;

endmodule

// File: tb/tb_vote_tally_engine.sv
// Directed self-checking bench for vote_tally_engine (NUM_CAND=4, CNT_W=4, 10-cycle debounce/ack).
module tb_vote_tally_engine;
  localparam int unsigned   NC   = 4;
  localparam int unsigned   CW   = 4;
  localparam int unsigned   SW   = 2;
  localparam logic [CW-1:0] Ones = '1;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   acks       = 0;

  vote_tally_engine_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  vote_tally_engine #(
    .NUM_CAND    (NC),
    .CNT_W       (CW),
    .DEBOUNCE_CYC(10),
    .ACK_CYC     (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && bus.vote_ack_o) acks++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, want finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm();
`ifdef VOTE_ARM_EN
    bus.ballot_arm_i = 1'b1;
    tick();
    bus.ballot_arm_i = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic read_tally(input int k, output logic [CW-1:0] v);
    bus.rd_sel_i = SW'(k);
    #1;
    v = bus.rd_data_o;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy_o && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (bus.busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_idle_timeout: got busy %b after %0d cycles, want 0", tag, bus.busy_o, n);
    end
    tick(2);
  endtask

  task automatic cast_vote(input int k);
    arm();
    bus.button_i = NC'(1) << k;
    tick(10);
    bus.button_i = '0;
    tick();
    wait_idle("cast");
  endtask

  task automatic test_reset();
    logic [CW-1:0] v;
    #2 reset_n = 1'b0;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      read_tally(k, v);
      compared++;
      if (v !== '0) begin
        mismatched++;
        $display("FAIL reset_tally%0d: got %0d, want 0", k, v);
      end
    end
    compared++;
    if ({bus.total_votes_o, bus.led_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_total_led: got %0d/%0d, want 0/0", bus.total_votes_o, bus.led_o);
    end
    compared++;
    if ({bus.busy_o, bus.vote_ack_o, bus.tie_o, bus.winner_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_flags: got busy %b ack %b tie %b win %0d, want all 0",
               bus.busy_o, bus.vote_ack_o, bus.tie_o, bus.winner_o);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_debounce_vote();
    logic [CW-1:0] v;
    int a0 = acks;
    int n  = 0;
    arm();
    bus.button_i = 4'b0010;
    tick(9);
    bus.button_i = '0;
    tick(3);
    compared++;
    if (bus.total_votes_o !== 4'd0) begin
      mismatched++;
      $display("FAIL short_press: got total %0d, want 0", bus.total_votes_o);
    end
    bus.button_i = 4'b0010;
    tick(10);
    bus.button_i = '0;
    compared++;
    if (bus.vote_ack_o !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_early: got %b, want 0", bus.vote_ack_o);
    end
    tick();
    compared++;
    if (bus.vote_ack_o !== 1'b1) begin
      mismatched++;
      $display("FAIL ack_latency: got %b, want 1", bus.vote_ack_o);
    end
    while (bus.led_o === Ones && n < 30) begin
      n++;
      tick();
    end
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL led_ack_cycles: got %0d, want 10", n);
    end
    compared++;
    if (acks - a0 !== 1) begin
      mismatched++;
      $display("FAIL ack_count: got %0d, want 1", acks - a0);
    end
    read_tally(1, v);
    compared++;
    if (v !== 4'd1 || bus.total_votes_o !== 4'd1) begin
      mismatched++;
      $display("FAIL first_vote: got tally1 %0d total %0d, want 1 1", v, bus.total_votes_o);
    end
    tick(2);
  endtask

  task automatic test_simultaneous();
    logic [CW-1:0] v2, v3;
    arm();
    bus.button_i = 4'b1100;
    tick(25);
    arm();
    tick(15);
    read_tally(2, v2);
    read_tally(3, v3);
    compared++;
    if (v2 !== 4'd1 || v3 !== 4'd0 || bus.total_votes_o !== 4'd2) begin
      mismatched++;
      $display("FAIL simultaneous_hold: got t2 %0d t3 %0d total %0d, want 1 0 2",
               v2, v3, bus.total_votes_o);
    end
    bus.button_i = '0;
    tick();
    cast_vote(2);
    read_tally(2, v2);
    compared++;
    if (v2 !== 4'd2 || bus.total_votes_o !== 4'd3) begin
      mismatched++;
      $display("FAIL repress: got t2 %0d total %0d, want 2 3", v2, bus.total_votes_o);
    end
  endtask

  task automatic test_no_arm();
    logic [CW-1:0] v, exp;
`ifdef VOTE_ARM_EN
    exp = 4'd0;
`else
    exp = 4'd1;
`endif
    do_reset();
    bus.button_i = 4'b0001;
    tick(10);
    bus.button_i = '0;
    tick(12);
    read_tally(0, v);
    compared++;
    if (v !== exp || bus.total_votes_o !== exp) begin
      mismatched++;
      $display("FAIL no_arm_press: got t0 %0d total %0d, want %0d", v, bus.total_votes_o, exp);
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] v;
    int a0;
    do_reset();
    a0 = acks;
    repeat (17) cast_vote(0);
    read_tally(0, v);
    compared++;
    if (v !== 4'd15 || bus.total_votes_o !== 4'd15) begin
      mismatched++;
      $display("FAIL saturate: got t0 %0d total %0d, want 15 15", v, bus.total_votes_o);
    end
    compared++;
    if (acks - a0 !== 17) begin
      mismatched++;
      $display("FAIL saturate_acks: got %0d, want 17", acks - a0);
    end
  endtask

  task automatic test_winner_readout();
    logic [CW-1:0] v;
    do_reset();
    repeat (3) cast_vote(0);
    compared++;
    if (bus.winner_o !== 2'd0 || bus.tie_o !== 1'b0) begin
      mismatched++;
      $display("FAIL winner_c0: got %0d/%b, want 0/0", bus.winner_o, bus.tie_o);
    end
    repeat (5) cast_vote(1);
    compared++;
    if (bus.winner_o !== 2'd1 || bus.tie_o !== 1'b0) begin
      mismatched++;
      $display("FAIL winner_c1: got %0d/%b, want 1/0", bus.winner_o, bus.tie_o);
    end
    repeat (5) cast_vote(2);
    cast_vote(3);
    compared++;
    if (bus.winner_o !== 2'd1 || bus.tie_o !== 1'b1) begin
      mismatched++;
      $display("FAIL winner_tie: got %0d/%b, want 1/1", bus.winner_o, bus.tie_o);
    end
    arm();
    bus.mode_i = 1'b1;
    tick();
    bus.button_i = 4'b0100;
    tick(10);
    bus.button_i = '0;
    tick();
    compared++;
    if (bus.led_o !== 4'd5 || bus.total_votes_o !== 4'd14) begin
      mismatched++;
      $display("FAIL led_readout: got led %0d total %0d, want 5 14", bus.led_o, bus.total_votes_o);
    end
    read_tally(3, v);
    compared++;
    if (v !== 4'd1) begin
      mismatched++;
      $display("FAIL rd_sel3: got %0d, want 1", v);
    end
    bus.button_i = 4'b1000;
    tick(10);
    bus.button_i = '0;
    tick();
    compared++;
    if (bus.led_o !== 4'd1) begin
      mismatched++;
      $display("FAIL led_relatch: got %0d, want 1", bus.led_o);
    end
    bus.mode_i = 1'b0;
    tick(2);
    bus.mode_i = 1'b1;
    tick();
    compared++;
    if (bus.led_o !== 4'd0 || bus.total_votes_o !== 4'd14) begin
      mismatched++;
      $display("FAIL led_mode_clear: got led %0d total %0d, want 0 14", bus.led_o, bus.total_votes_o);
    end
    bus.mode_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [CW-1:0] v;
    do_reset();
    arm();
    bus.button_i = 4'b0010;
    tick(10);
    bus.button_i = '0;
    tick(4);
    read_tally(1, v);
    compared++;
    if (bus.busy_o !== 1'b1 || v !== 4'd1) begin
      mismatched++;
      $display("FAIL pre_reset_ack: got busy %b t1 %0d, want 1 1", bus.busy_o, v);
    end
    #1 reset_n = 1'b0;
    read_tally(1, v);
    compared++;
    if (v !== '0 || bus.total_votes_o !== '0 || bus.led_o !== '0 || bus.busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got t1 %0d total %0d led %0d busy %b, want 0 0 0 0",
               v, bus.total_votes_o, bus.led_o, bus.busy_o);
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.mode_i   = 1'b0;
    bus.button_i = '0;
    bus.rd_sel_i = '0;
`ifdef VOTE_ARM_EN
    bus.ballot_arm_i = 1'b0;
`endif
    test_reset();
    test_debounce_vote();
    test_simultaneous();
    test_no_arm();
    test_saturation();
    test_winner_readout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
